case_2_mul_share_arbiter: RTL and testbench
===========================================

// Module: case_2_mul_share_arbiter
// PURPOSE
//  Shares one signed multiplier (A_W-bit x B_W-bit, truncated to P_W bits) among NUM_REQ requesters.
//  Sits between kernel datapath lanes and the single multiplier instance.
//  - Per-lane operand channel: valid/ready.
//  - Round-robin arbitration across lanes.
//  - Registered operands and product.
//  - Single tagged response channel, valid/ready.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ID_W     2   response tag width, clog2(NUM_REQ)
//  A_W      8   operand A width, signed
//  B_W      6   operand B width, signed
//  P_W      10  product width; low P_W bits of full A_W+B_W product
// PORTS
//  ap_clk     in   1            clock, rising edge
//  ap_rst_n   in   1            asynchronous active-low reset
//  req_valid  in   NUM_REQ      per-lane operand valid
//  req_ready  out  NUM_REQ      per-lane accept; one-hot or zero
//  req_a      in   NUM_REQ*A_W  packed operand A; lane i at [i*A_W +: A_W]
//  req_b      in   NUM_REQ*B_W  packed operand B; lane i at [i*B_W +: B_W]
//  rsp_valid  out  1            product valid
//  rsp_ready  in   1            consumer accepts product
//  rsp_id     out  ID_W         lane index that issued the product
//  rsp_data   out  P_W          truncated signed product
//  busy       out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, while ap_rst_n=0):
//    - state=IDLE; rr_ptr=0.
//    - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
//    - Operand registers cleared.
//  - FSM states: IDLE -> CALC -> RESP -> IDLE.
//    - IDLE:
//      - Grant g = first lane with req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//      - req_ready[g]=1 (combinational); all other lanes 0. No lane valid -> req_ready=0.
//      - Accept = req_valid[g] & req_ready[g].
//      - On accept: latch req_a/req_b of lane g and tag=g; rr_ptr <= (g+1) mod NUM_REQ; go CALC.
//    - CALC:
//      - Compute $signed(op_a)*$signed(op_b) at full A_W+B_W width.
//      - Register low P_W bits into rsp_data and tag into rsp_id; set rsp_valid=1; go RESP.
//    - RESP:
//      - Hold rsp_valid/rsp_id/rsp_data stable until rsp_ready=1.
//      - On the handshake edge: rsp_valid <= 0; go IDLE.
//      - No new accept in RESP or CALC; req_ready=0 in both.
//  - Latency:
//    - Accept on edge k -> rsp_valid=1 after edge k+1.
//    - Minimum issue interval is 3 cycles.
//  - Width rule: no saturation; the product wraps modulo 2^P_W.
//  - rsp_data and rsp_id keep their last value after the response handshake.
//  - req_valid may drop without handshake; arbitration re-evaluates every IDLE cycle.
//  - Only the accepted lane's data is captured; later changes on req_a/req_b have no effect.
//  - rr_ptr advances only on accept.
//  - Reset mid-operation: any in-flight product is discarded and state returns to IDLE;
//    requesters must reissue.
//  - Out-of-range lanes (index >= NUM_REQ) do not exist; rr_ptr never exceeds NUM_REQ-1.
// TESTING
//  1. Single lane 0, a=-3 (0xFD), b=5, rsp_ready=1
//     -> rsp_valid 2 edges after accept, rsp_data=0x3F1, rsp_id=0.
//  2. Overflow: a=-128, b=-32 -> 0x000; a=127, b=31 -> 0x361; a=-128, b=31 -> 0x080.
//  3. All 4 lanes valid continuously, rsp_ready=1
//     -> grants 0,1,2,3,0,...; one accept every 3 cycles; rsp_id follows the same order.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP
//     -> rsp_valid and rsp_data stable; req_ready=0 throughout; release -> IDLE on next edge.
//  5. Lanes 1 and 3 valid, rr_ptr=2 -> lane 3 first, then lane 1; rr_ptr ends at 2.
//  6. Assert ap_rst_n=0 asynchronously during CALC
//     -> rsp_valid and busy drop immediately; after release the first grant goes to lane 0.

Source files
------------

// File: rtl/case_2_mul_share_arbiter.sv
// Shares one registered signed multiplier among NUM_REQ requesters.
// Round-robin grant in IDLE, one cycle of multiply, then a tagged response
// held until the consumer takes it.

// Per-lane candidacy: a valid lane at or above the round-robin pointer
// wins over the wrap-around lanes below it.
module case_2_mul_share_arbiter_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            valid,
  input  logic [ID_W-1:0] ptr,
  output logic            hi
);
  assign hi = valid && (int'(ptr) <= IDX);
endmodule

module case_2_mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 8,
  parameter int B_W     = 6,
  parameter int P_W     = 10
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_data,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      tag;
  logic [A_W-1:0]       op_a;
  logic [B_W-1:0]       op_b;
  logic [NUM_REQ-1:0]   hi_valid;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic                 accept;
  logic [ID_W-1:0]      ptr_nxt;
  logic signed [A_W+B_W-1:0] prod;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      case_2_mul_share_arbiter_lane #(.ID_W(ID_W), .IDX(gi)) u_lane (
        .valid (req_valid[gi]),
        .ptr   (rr_ptr),
        .hi    (hi_valid[gi])
      );
    end
  endgenerate

  // Grant: lowest valid lane at/after rr_ptr, else lowest valid lane overall (wrap).
  always_comb begin
    gnt_any = |req_valid;
    gnt_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) gnt_id = ID_W'(i);
    if (|hi_valid)
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (hi_valid[i]) gnt_id = ID_W'(i);
  end

  assign req_ready = (state == S_IDLE && gnt_any) ?
                     ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_nxt   = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
  assign prod      = $signed(op_a) * $signed(op_b);
  assign busy      = (state != S_IDLE);

  // Control FSM, operand capture and response register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      tag       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_a   <= req_a[gnt_id*A_W +: A_W];
          op_b   <= req_b[gnt_id*B_W +: B_W];
          tag    <= gnt_id;
          rr_ptr <= ptr_nxt;
          state  <= S_CALC;
        end
        S_CALC: begin
          // Product wraps: only the low P_W bits are kept.
          rsp_data  <= prod[P_W-1:0];
          rsp_id    <= tag;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_2_mul_share_arbiter.sv
// Scoreboard bench: a negedge monitor predicts grants from a round-robin
// pointer and queues expected products; responses are popped and compared.
module tb_case_2_mul_share_arbiter;
  localparam int NR = 4, IW = 2, AW = 8, BW = 6, PW = 10;

  logic             ap_clk = 0, ap_rst_n = 0;
  logic [NR-1:0]    req_valid = '0, req_ready;
  logic [NR-1:0][AW-1:0] la = '0;
  logic [NR-1:0][BW-1:0] lb = '0;
  logic [NR*AW-1:0] req_a;
  logic [NR*BW-1:0] req_b;
  logic             rsp_valid, rsp_ready = 0, busy;
  logic [IW-1:0]    rsp_id;
  logic [PW-1:0]    rsp_data;

  assign req_a = la;
  assign req_b = lb;

  case_2_mul_share_arbiter #(.NUM_REQ(NR), .ID_W(IW), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));

  always #5 ap_clk = ~ap_clk;

  typedef struct { int id; int d; } exp_t;
  exp_t sb[$];
  int   glog[$];
  int   tests = 0, fails = 0;
  int   m_rr = 0, cyc = 0, acc_cyc = 0, n_acc = 0;
  bit   m_idle = 1, rsp_seen = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first valid lane scanning from the pointer, modulo NR.
  function automatic logic [NR-1:0] exp_ready(logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      int l = (m_rr + k) % NR;
      if (v[l]) return NR'(1) << l;
    end
    return '0;
  endfunction

  function automatic int ref_prod(int l);
    int a = int'($signed(la[l]));
    int b = int'($signed(lb[l]));
    return (a * b) & ((1 << PW) - 1);
  endfunction

  always @(posedge ap_clk) cyc++;

  // Monitor: grant prediction, scoreboard push on accept, compare on response.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      sb.delete(); m_idle = 1; m_rr = 0; rsp_seen = 0;
    end else begin
      logic [NR-1:0] er, acc;
      er = m_idle ? exp_ready(req_valid) : '0;
      chk("req_ready", int'(req_ready), int'(er));
      chk("busy", int'(busy), int'(!m_idle));
      acc = req_valid & req_ready;
      if (|acc) begin
        int g = 0;
        for (int i = 0; i < NR; i++) if (acc[i]) g = i;
        sb.push_back('{id: g, d: ref_prod(g)});
        glog.push_back(g);
        m_rr = (g + 1) % NR; m_idle = 0; acc_cyc = cyc; n_acc++;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp_id", int'(rsp_id), sb[0].id);
          chk("rsp_data", int'(rsp_data), sb[0].d);
          if (!rsp_seen) chk("latency", cyc - acc_cyc, 2);
          rsp_seen = 1;
          if (rsp_ready) begin
            void'(sb.pop_front()); rsp_seen = 0; m_idle = 1;
          end
        end
      end
    end
  end

  task automatic wait_idle(int maxc);
    int n = 0;
    do begin @(negedge ap_clk); n++; end while (!(m_idle && sb.size() == 0) && n < maxc);
    if (!(m_idle && sb.size() == 0)) chk("idle_timeout", 0, 1);
  endtask

  task automatic issue_chk(int lane, int a, int b, int exp);
    int n = 0;
    req_valid[lane] = 1; la[lane] = AW'(a); lb[lane] = BW'(b);
    do begin @(negedge ap_clk); n++; end while (!req_ready[lane] && n < 20);
    if (!req_ready[lane]) chk("grant_timeout", 0, 1);
    @(posedge ap_clk); #1 req_valid[lane] = 0;
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!rsp_valid && n < 20);
    chk("golden_data", int'(rsp_data), exp);
    chk("golden_id", int'(rsp_id), lane);
    wait_idle(30);
  endtask

  initial begin
    int n0, n;
    #3;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    @(posedge ap_clk); #1 ap_rst_n = 1; rsp_ready = 1;

    // Single lane and wrap-around products.
    issue_chk(0, -3, 5, 'h3F1);
    issue_chk(0, -128, -32, 'h000);
    issue_chk(0, 127, 31, 'h361);
    issue_chk(0, -128, 31, 'h080);

    // All lanes valid continuously: one accept every 3 cycles.
    n0 = n_acc;
    for (int i = 0; i < 24; i++) begin
      @(posedge ap_clk); #1 req_valid = '1;
      for (int l = 0; l < NR; l++) begin la[l] = AW'($urandom); lb[l] = BW'($urandom); end
    end
    @(posedge ap_clk); #1 req_valid = '0;
    chk("rr_accept_count", n_acc - n0, 8);
    wait_idle(30);

    // Backpressure: hold the response for 5 cycles.
    rsp_ready = 0;
    req_valid[2] = 1; la[2] = AW'(-77); lb[2] = BW'(13);
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!req_ready[2] && n < 20);
    @(posedge ap_clk); #1 req_valid = '1;
    repeat (7) @(posedge ap_clk);
    #1 req_valid = '0; rsp_ready = 1;
    wait_idle(30);

    // Pointer at 2 with lanes 1 and 3 pending: lane 3 then lane 1.
    issue_chk(1, 9, -7, 'h3C1);
    glog.delete();
    req_valid = 4'b1010;
    n = 0;
    do begin @(posedge ap_clk); #1 n++; end while (glog.size() < 2 && n < 30);
    req_valid = '0;
    wait_idle(30);
    chk("rr_first", glog.size() > 0 ? glog[0] : -1, 3);
    chk("rr_second", glog.size() > 1 ? glog[1] : -1, 1);

    // Randomized traffic with random backpressure and valid drops.
    for (int i = 0; i < 400; i++) begin
      @(posedge ap_clk); #1;
      req_valid = NR'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      for (int l = 0; l < NR; l++) begin la[l] = AW'($urandom); lb[l] = BW'($urandom); end
    end
    req_valid = '0; rsp_ready = 1;
    wait_idle(30);

    // Asynchronous reset while in CALC.
    req_valid[2] = 1; la[2] = 8'd5; lb[2] = 6'd3;
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!req_ready[2] && n < 20);
    @(posedge ap_clk); #2 ap_rst_n = 0; req_valid = '0;
    #1;
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge ap_clk); #1 ap_rst_n = 1; req_valid = '1;
    @(negedge ap_clk);
    chk("post_rst_grant", int'(req_ready), 1);
    @(posedge ap_clk); #1 req_valid = '0;
    wait_idle(30);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
